measure_seq: RTL and testbench
==============================

// Module: measure_seq
// PURPOSE
// - Sequencer for the reciprocal frequency-measurement datapath (gate/sync/counter block).
// - Issues gate-start pulses, tracks the synchronised gate and the result-write strobe.
// - Accumulates N back-to-back {clk_cnt, sig_cnt} results and presents the sums to the AXI register layer.
// - Supports single-shot and continuous operation; a host abort returns it to idle.
// PARAMETERS
// - ROUNDS_W     8           width of rounds_i; accumulator width = 32 + ROUNDS_W
// - TIMEOUT_CYC  32'd25_000_000  watchdog limit per round, clk_i cycles (timeout feature only)
// PORTS
// - clk_i          in   1    system clock
// - rst_n_i        in   1    asynchronous active-low reset
// - start_i        in   1    1-cycle pulse: begin a measurement run (ignored unless IDLE)
// - abort_i        in   1    level: abandon run, go IDLE (priority over all other inputs)
// - cont_i         in   1    1 = restart automatically after each completed run
// - rounds_i       in   ROUNDS_W  gates per run; 0 is treated as 1; sampled at start
// - gate_time_i    in   8    forwarded unchanged to datapath, sampled at start
// - gate_st_o      out  1    1-cycle gate-start pulse to datapath
// - gate_time_o    out  8    latched gate_time to datapath
// - gate_sync_i    in   1    synchronised gate from datapath
// - reg_wr_en_i    in   1    result strobe from datapath (1 cycle)
// - reg_wr_data_i  in   64   {clk_cnt[63:32], sig_cnt[31:0]} from datapath
// - busy_o         out  1    1 in every state except IDLE
// - res_valid_o    out  1    1-cycle pulse: sums below are final for this run
// - res_sig_sum_o  out  32+ROUNDS_W  sum of sig_cnt over run
// - res_clk_sum_o  out  32+ROUNDS_W  sum of clk_cnt over run
// - err_o          out  1    sticky timeout flag, cleared on next accepted start_i
// BEHAVIOUR
// - Reset: all outputs 0; FSM = IDLE; accumulators 0; remaining-round counter 0.
// - FSM states: IDLE, ARM, WAIT_SYNC, WAIT_DONE, ACCUM, DONE.
// - IDLE: on start_i, latch rounds (0->1) and gate_time_i, clear accumulators and err_o, go to ARM.
// - ARM: assert gate_st_o for exactly this cycle, go to WAIT_SYNC.
// - WAIT_SYNC: wait for a gate_sync_i rising edge (registered compare), then go to WAIT_DONE.
// - WAIT_DONE: on reg_wr_en_i, capture reg_wr_data_i into a holding register, go to ACCUM.
//   - A strobe arriving in the same cycle as the sync edge is accepted.
// - ACCUM: add data[31:0] to the sig sum and data[63:32] to the clk sum, zero-extended, no saturation.
//   - Decrement remaining; if remaining becomes 0, go to DONE, else go to ARM.
// - DONE: pulse res_valid_o for 1 cycle (sums stable from this cycle until the next accepted start).
//   - If cont_i is 1, behave as an internal start with fresh latches; otherwise go to IDLE.
// - Latency: start_i -> gate_st_o = 2 cycles. Final strobe -> res_valid_o = 3 cycles.
// - abort_i in any state: next state IDLE; no res_valid_o; sums hold their partial values; gate_st_o is not asserted.
//   - Any pending datapath strobe after an abort is ignored in IDLE.
// - reg_wr_en_i outside WAIT_DONE is ignored.
// - start_i while busy is ignored.
// - Reset mid-run: immediate return to reset values.
// - Worst-case accumulation: 2^ROUNDS_W * (2^32-1) fits in 32+ROUNDS_W bits; no overflow possible.
// CONFIGURATION
// - MEASURE_SEQ_TIMEOUT_EN defined:
//   - A 32-bit watchdog counts in WAIT_SYNC/WAIT_DONE and resets on every state entry.
//   - On reaching TIMEOUT_CYC: set err_o, go to IDLE (no res_valid_o), and cont_i is not honoured.
// - Macro undefined: no watchdog; err_o tied 0; WAIT states exit only via the datapath or abort_i.
// TESTING
// - rounds_i=1, gate_time=1, datapath returns {32'd100, 32'd10} -> one gate_st_o, res_valid_o, sums 10/100.
// - rounds_i=3, returns sig 5,6,7 / clk 50,60,70 -> exactly 3 gate_st_o pulses, sums 18/180, single res_valid_o.
// - rounds_i=0 -> treated as 1 round; rounds_i=255, data 32'hFFFF_FFFF each -> sig sum 40'hFE_FFFF_FF01, no wrap.
// - abort_i asserted in WAIT_DONE, then strobe arrives -> IDLE, busy_o=0, no res_valid_o, sums unchanged.
// - cont_i=1, rounds_i=2 -> res_valid_o every run, gate_st_o resumes within 2 cycles; start_i while busy ignored.
// - MEASURE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, gate_sync_i held 0 -> err_o=1 at cycle 100 of WAIT_SYNC, IDLE.
//   - Next start_i clears err_o.

Source files
------------

// File: rtl/measure_seq.sv
// measure_seq: run sequencer for the reciprocal frequency-measurement datapath.
// Issues gate-start pulses, follows the synchronised gate and the result strobe,
// and sums {clk_cnt, sig_cnt} over a run of N gates for the register layer.
// Single-shot or continuous runs; abort_i returns to IDLE from anywhere.
// Optional feature macro: MEASURE_SEQ_TIMEOUT_EN (per-round watchdog and err_o).
module measure_seq #(
    parameter int unsigned ROUNDS_W = 8
`ifdef MEASURE_SEQ_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYC = 32'd25_000_000
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    cont_i,
    input  logic [ROUNDS_W-1:0]     rounds_i,
    input  logic [7:0]              gate_time_i,
    output logic                    gate_st_o,
    output logic [7:0]              gate_time_o,
    input  logic                    gate_sync_i,
    input  logic                    reg_wr_en_i,
    input  logic [63:0]             reg_wr_data_i,
    output logic                    busy_o,
    output logic                    res_valid_o,
    output logic [32+ROUNDS_W-1:0]  res_sig_sum_o,
    output logic [32+ROUNDS_W-1:0]  res_clk_sum_o,
    output logic                    err_o
);

    localparam int unsigned ACC_W = 32 + ROUNDS_W;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_SYNC,
        WAIT_DONE,
        ACCUM,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                sync_q;      // previous gate_sync_i, for edge detect
    logic                sync_rise;
    logic [ROUNDS_W-1:0] remaining;   // gates still to accumulate in this run
    logic                fresh;       // next ACCUM is the first of a run
    logic [63:0]         data_p0;     // captured datapath result
    logic                load_run;    // latch rounds/gate_time for a new run
    logic                clear_sums;
    logic                capture;
    logic                accum_en;

    // Zero-extend a 32-bit count to accumulator width.
    function automatic logic [ACC_W-1:0] widen(input logic [31:0] v);
        return {{ROUNDS_W{1'b0}}, v};
    endfunction

    // First round of a run replaces the sum, later rounds add to it. This keeps
    // the previous run's sums readable after a continuous restart until new
    // data actually arrives.
    function automatic logic [ACC_W-1:0] accumulate(input logic first,
                                                    input logic [ACC_W-1:0] sum,
                                                    input logic [31:0] v);
        return first ? widen(v) : (sum + widen(v));
    endfunction

    assign sync_rise = gate_sync_i & ~sync_q;
    assign busy_o    = (state != IDLE);

`ifdef MEASURE_SEQ_TIMEOUT_EN
    logic [31:0] wdog;
    logic        in_wait;
    logic        wait_event;
    logic        timeout;
    logic        err_q;

    assign in_wait    = (state == WAIT_SYNC) || (state == WAIT_DONE);
    assign wait_event = (state == WAIT_SYNC) ? sync_rise : reg_wr_en_i;
    assign timeout    = in_wait && !wait_event && (wdog == TIMEOUT_CYC - 32'd1);
    assign err_o      = err_q;

    // Watchdog: restarts on every state entry, counts only while waiting on the datapath
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdog <= '0;
        end else if (state_next != state || !in_wait) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 32'd1;
        end
    end

    // Sticky timeout flag, cleared when a new run is latched
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (load_run) begin
            err_q <= 1'b0;
        end else if (timeout && !abort_i) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    // Next-state and per-cycle control decode; abort overrides everything
    always_comb begin
        state_next = state;
        load_run   = 1'b0;
        clear_sums = 1'b0;
        capture    = 1'b0;
        accum_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = ARM;
                    load_run   = 1'b1;
                    clear_sums = 1'b1;
                end
            end
            ARM: begin
                state_next = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (sync_rise) begin
                    if (reg_wr_en_i) begin
                        capture    = 1'b1;
                        state_next = ACCUM;
                    end else begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (reg_wr_en_i) begin
                    capture    = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                accum_en   = 1'b1;
                state_next = (remaining <= ROUNDS_W'(1)) ? DONE : ARM;
            end
            DONE: begin
                if (cont_i) begin
                    state_next = ARM;
                    load_run   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef MEASURE_SEQ_TIMEOUT_EN
        if (timeout) begin
            state_next = IDLE;
            load_run   = 1'b0;
        end
`endif
        if (abort_i) begin
            state_next = IDLE;
            load_run   = 1'b0;
            clear_sums = 1'b0;
            capture    = 1'b0;
            accum_en   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run bookkeeping, registered strobes and result accumulators
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q        <= 1'b0;
            remaining     <= '0;
            fresh         <= 1'b0;
            gate_time_o   <= '0;
            gate_st_o     <= 1'b0;
            res_valid_o   <= 1'b0;
            res_sig_sum_o <= '0;
            res_clk_sum_o <= '0;
        end else begin
            sync_q      <= gate_sync_i;
            gate_st_o   <= (state == ARM) && !abort_i;
            res_valid_o <= (state == DONE) && !abort_i;
            if (load_run) begin
                remaining   <= (rounds_i == '0) ? ROUNDS_W'(1) : rounds_i;
                gate_time_o <= gate_time_i;
                fresh       <= 1'b1;
            end
            if (clear_sums) begin
                res_sig_sum_o <= '0;
                res_clk_sum_o <= '0;
            end
            if (accum_en) begin
                remaining     <= remaining - ROUNDS_W'(1);
                fresh         <= 1'b0;
                res_sig_sum_o <= accumulate(fresh, res_sig_sum_o, data_p0[31:0]);
                res_clk_sum_o <= accumulate(fresh, res_clk_sum_o, data_p0[63:32]);
            end
        end
    end

    // Result holding register; pure data, no reset needed
    always_ff @(posedge clk_i) begin
        if (capture) begin
            data_p0 <= reg_wr_data_i;
        end
    end

endmodule

// File: tb/tb_measure_seq.sv
// tb_measure_seq: randomized bench for measure_seq with a behavioural datapath
// responder and a run-level reference model (queue of returned results).
`timescale 1ns/1ps
module tb_measure_seq;

    localparam int RW = 8;
`ifdef MEASURE_SEQ_TIMEOUT_EN
    localparam logic [31:0] TO_CYC = 32'd100;
`endif

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic           start_i;
    logic           abort_i;
    logic           cont_i;
    logic [RW-1:0]  rounds_i;
    logic [7:0]     gate_time_i;
    logic           gate_st_o;
    logic [7:0]     gate_time_o;
    logic           gate_sync_i;
    logic           reg_wr_en_i;
    logic [63:0]    reg_wr_data_i;
    logic           busy_o;
    logic           res_valid_o;
    logic [31+RW:0] res_sig_sum_o;
    logic [31+RW:0] res_clk_sum_o;
    logic           err_o;

    always #5 clk = ~clk;

    measure_seq #(
        .ROUNDS_W(RW)
`ifdef MEASURE_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .cont_i        (cont_i),
        .rounds_i      (rounds_i),
        .gate_time_i   (gate_time_i),
        .gate_st_o     (gate_st_o),
        .gate_time_o   (gate_time_o),
        .gate_sync_i   (gate_sync_i),
        .reg_wr_en_i   (reg_wr_en_i),
        .reg_wr_data_i (reg_wr_data_i),
        .busy_o        (busy_o),
        .res_valid_o   (res_valid_o),
        .res_sig_sum_o (res_sig_sum_o),
        .res_clk_sum_o (res_clk_sum_o),
        .err_o         (err_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: results returned by the datapath during the current run
    logic [63:0] sent[$];
    logic [63:0] dir_q[$];
    bit          dp_max = 1'b0;
    bit          dp_mute = 1'b0;
    int          dp_hold_after = -1;
    int          last_strb_cyc = 0;

    int          eff_rounds = 1;
    int          n_gate = 0;
    int          n_valid = 0;
    int          gate_since = 0;
    int          first_gate_cyc = -1;
    int          valid_cyc = -1;
    int          start_cyc = 0;
    bit          resume_pending = 1'b0;
    logic [7:0]  exp_gt = '0;
    logic [63:0] exp_sig;
    logic [63:0] exp_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_sums();
        exp_sig = '0;
        exp_clk = '0;
        foreach (sent[i]) begin
            exp_sig += {32'd0, sent[i][31:0]};
            exp_clk += {32'd0, sent[i][63:32]};
        end
    endtask

    // Behavioural datapath: answers each gate-start with a sync pulse and one result
    initial begin : datapath
        logic [63:0] d;
        bit          stale;
        gate_sync_i   = 1'b0;
        reg_wr_en_i   = 1'b0;
        reg_wr_data_i = '0;
        forever begin
            @(posedge clk); #1;
            if (gate_st_o && !dp_mute) begin
                stale = (dp_hold_after >= 0) && (sent.size() >= dp_hold_after);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                gate_sync_i = 1'b1;
                if (stale) begin
                    repeat (8) begin @(posedge clk); #1; end
                end else if ($urandom_range(0, 3) != 0) begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                end
                if (dir_q.size() > 0) d = dir_q.pop_front();
                else if (dp_max) d = '1;
                else d = {$urandom, $urandom};
                reg_wr_data_i = d;
                reg_wr_en_i   = 1'b1;
                if (!stale) sent.push_back(d);
                last_strb_cyc = cyc;
                @(posedge clk); #1;
                reg_wr_en_i = 1'b0;
                gate_sync_i = 1'b0;
            end
        end
    end

    // One clock; observe outputs and check each completed run against the model
    task automatic tick();
        @(posedge clk); #2;
        if (gate_st_o) begin
            n_gate++;
            gate_since++;
            if (first_gate_cyc < 0) first_gate_cyc = cyc;
            if (resume_pending) begin
                check_eq("cont_resume", ((cyc - valid_cyc) <= 2), 1);
                resume_pending = 1'b0;
            end
        end
        if (res_valid_o) begin
            n_valid++;
            valid_cyc = cyc;
            model_sums();
            check_eq("sig_sum", res_sig_sum_o, exp_sig);
            check_eq("clk_sum", res_clk_sum_o, exp_clk);
            check_eq("strobes_per_run", sent.size(), eff_rounds);
            check_eq("gates_per_run", gate_since, eff_rounds);
            check_eq("strobe_to_valid", cyc - last_strb_cyc, 3);
            check_eq("gate_time_o", gate_time_o, exp_gt);
            sent.delete();
            gate_since = 0;
            resume_pending = cont_i;
        end
    endtask

    task automatic start_run(input int rnd, input bit cont, input logic [7:0] gt);
        rounds_i       = rnd[RW-1:0];
        gate_time_i    = gt;
        cont_i         = cont;
        exp_gt         = gt;
        eff_rounds     = (rnd == 0) ? 1 : rnd;
        sent.delete();
        n_gate         = 0;
        n_valid        = 0;
        gate_since     = 0;
        first_gate_cyc = -1;
        valid_cyc      = -1;
        resume_pending = 1'b0;
        start_cyc      = cyc;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
        if (!cont) begin
            rounds_i    = RW'($urandom);
            gate_time_i = 8'($urandom);
        end
    endtask

    task automatic wait_valid(input int n, input int budget);
        int k = 0;
        while (n_valid < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("valid_reached", n_valid, n);
    endtask

    initial begin : global_guard
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    initial begin : main
        int rnd;
        int k;
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; cont_i = 1'b0;
        rounds_i = '0; gate_time_i = '0;
        tick(); tick();
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_gate_st", gate_st_o, 0);
        check_eq("rst_valid", res_valid_o, 0);
        check_eq("rst_sig_sum", res_sig_sum_o, 0);
        check_eq("rst_clk_sum", res_clk_sum_o, 0);
        check_eq("rst_gate_time", gate_time_o, 0);
        check_eq("rst_err", err_o, 0);
        rst_n_i = 1'b1;
        tick(); tick();

        // single round, fixed data
        dir_q.push_back({32'd100, 32'd10});
        start_run(1, 1'b0, 8'd1);
        wait_valid(1, 200);
        check_eq("lat_start_gate", first_gate_cyc - start_cyc, 2);
        check_eq("d1_sig", res_sig_sum_o, 10);
        check_eq("d1_clk", res_clk_sum_o, 100);
        repeat (4) tick();
        check_eq("d1_hold_sig", res_sig_sum_o, 10);
        check_eq("d1_idle", busy_o, 0);
        check_eq("d1_gates", n_gate, 1);
        check_eq("d1_valids", n_valid, 1);

        // three rounds, fixed data
        dir_q.push_back({32'd50, 32'd5});
        dir_q.push_back({32'd60, 32'd6});
        dir_q.push_back({32'd70, 32'd7});
        start_run(3, 1'b0, 8'($urandom));
        wait_valid(1, 300);
        check_eq("d3_sig", res_sig_sum_o, 18);
        check_eq("d3_clk", res_clk_sum_o, 180);
        repeat (4) tick();
        check_eq("d3_gates", n_gate, 3);
        check_eq("d3_valids", n_valid, 1);

        // rounds 0 behaves as one round
        start_run(0, 1'b0, 8'($urandom));
        wait_valid(1, 200);
        repeat (4) tick();
        check_eq("r0_gates", n_gate, 1);
        check_eq("r0_idle", busy_o, 0);

        // random run lengths and data
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom_range(1, 6);
            start_run(rnd, 1'b0, 8'($urandom));
            wait_valid(1, 60 * rnd + 50);
            repeat (4) tick();
            check_eq("rand_gates", n_gate, rnd);
            check_eq("rand_valids", n_valid, 1);
            check_eq("rand_idle", busy_o, 0);
        end

        // maximum run with all-ones data: no wrap
        dp_max = 1'b1;
        start_run(255, 1'b0, 8'($urandom));
        wait_valid(1, 255 * 16 + 100);
        check_eq("max_sig", res_sig_sum_o, 64'h00FE_FFFF_FF01);
        check_eq("max_clk", res_clk_sum_o, 64'h00FE_FFFF_FF01);
        dp_max = 1'b0;
        repeat (4) tick();

        // abort while waiting for the second result; the late strobe is ignored
        dp_hold_after = 1;
        start_run(2, 1'b0, 8'($urandom));
        k = 0;
        while (n_gate < 2 && k < 100) begin tick(); k++; end
        check_eq("abort_reach_gate2", n_gate, 2);
        repeat (5) tick();
        check_eq("abort_pre_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        repeat (15) tick();
        model_sums();
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_valids", n_valid, 0);
        check_eq("abort_gates", n_gate, 2);
        check_eq("abort_sig_hold", res_sig_sum_o, exp_sig);
        check_eq("abort_clk_hold", res_clk_sum_o, exp_clk);
        dp_hold_after = -1;

        // continuous mode, start while busy ignored, then stop after the third run
        start_run(2, 1'b1, 8'($urandom));
        wait_valid(1, 300);
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_valid(2, 300);
        cont_i = 1'b0;
        wait_valid(3, 300);
        repeat (5) tick();
        check_eq("cont_busy", busy_o, 0);
        check_eq("cont_valids", n_valid, 3);
        check_eq("cont_gates", n_gate, 6);

        // reset in the middle of a run
        start_run(3, 1'b0, 8'($urandom));
        repeat (6) tick();
        rst_n_i = 1'b0;
        #1;
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_gate_st", gate_st_o, 0);
        check_eq("midrst_sig", res_sig_sum_o, 0);
        check_eq("midrst_clk", res_clk_sum_o, 0);
        check_eq("midrst_gate_time", gate_time_o, 0);
        tick();
        rst_n_i = 1'b1;
        repeat (15) tick();
        check_eq("midrst_valids", n_valid, 0);
        check_eq("midrst_idle", busy_o, 0);

`ifdef MEASURE_SEQ_TIMEOUT_EN
        // watchdog: datapath silent, err_o sets after TO_CYC cycles of WAIT_SYNC
        dp_mute = 1'b1;
        start_run(1, 1'b1, 8'($urandom));
        k = 0;
        while (!err_o && k < 300) begin tick(); k++; end
        check_eq("to_err", err_o, 1);
        check_eq("to_cycle", cyc - start_cyc, TO_CYC + 2);
        repeat (3) tick();
        check_eq("to_idle", busy_o, 0);
        check_eq("to_valids", n_valid, 0);
        dp_mute = 1'b0;
        start_run(1, 1'b0, 8'($urandom));
        check_eq("to_err_clear", err_o, 0);
        wait_valid(1, 200);
        repeat (4) tick();
`else
        check_eq("err_tied", err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
